pack_receiver: RTL

Receive-side counterpart of the Modulator. Accepts the 80-bit I/Q sample stream (two samples per bit), makes hard bit decisions, hunts for the 32-bit preamble with an error tolerance, then de-frames the 1944 payload bits of each 1976-bit pack into bytes. Bytes are delivered through a 4-entry output FIFO with a valid/ready handshake and a last-byte marker.

---
 rtl/pack_receiver.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pack_receiver.sv
// pack_receiver: hard-decision I/Q receiver with error-tolerant preamble hunt,
// payload de-framing into MSB-first bytes and a small output FIFO.
module pack_receiver #(
    parameter int                   SIZE_SAMPLE     = 33,
    parameter int                   SIZE_BIT_PACK   = 1976,
    parameter int                   SIZE_PREAMBLE   = 32,
    parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE    = 32'h1ACFFC1D,
    parameter int                   MAX_ERR         = 2,
    parameter int                   SIZE_OUTPUT_BIT = 8,
    parameter int                   FIFO_DEPTH      = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [79:0]                i_data,
    input  logic                       i_valid_input,
    output logic                       o_ready,
    output logic [SIZE_OUTPUT_BIT-1:0] o_data,
    output logic                       o_valid_output,
    input  logic                       i_ready,
    output logic                       o_last,
    output logic                       o_lock
);

    localparam int NUM_BYTES  = (SIZE_BIT_PACK - SIZE_PREAMBLE) / SIZE_OUTPUT_BIT;
    localparam int BYTE_CNT_W = $clog2(NUM_BYTES);
    localparam int BIT_CNT_W  = $clog2(SIZE_OUTPUT_BIT);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(NUM_BYTES - 1);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(SIZE_OUTPUT_BIT - 1);
    localparam logic [PTR_W:0]        FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {HUNT, PAYLOAD} state_t;

    state_t                       state_q, state_d;
    logic [SIZE_SAMPLE-1:0]       i_cur, i_prev;
    logic [SIZE_SAMPLE:0]         sum;
    logic                         bit_dec, accept, phase, lock_phase;
    logic [SIZE_PREAMBLE-2:0]     shift_q [2];
    logic [SIZE_PREAMBLE-1:0]     next_shift;
    int                           err_cnt;
    logic                         hit;
    logic [SIZE_OUTPUT_BIT-2:0]   byte_q;
    logic [SIZE_OUTPUT_BIT-1:0]   byte_next;
    logic [BIT_CNT_W-1:0]         bit_cnt;
    logic [BYTE_CNT_W-1:0]        byte_cnt;
    logic                         payload_bit, byte_done, pack_done;
    logic                         wr_pend, wr_last;
    logic [SIZE_OUTPUT_BIT-1:0]   wr_data;
    logic [SIZE_OUTPUT_BIT-1:0]   fifo_data [FIFO_DEPTH];
    logic                         fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr, rd_ptr;
    logic [PTR_W:0]               count;
    logic                         rd_en;
    logic                         unused_bits;

    // Sum of two consecutive I samples, sign-extended so it cannot overflow
    assign i_cur   = i_data[SIZE_SAMPLE-1:0];
    assign sum     = {i_prev[SIZE_SAMPLE-1], i_prev} + {i_cur[SIZE_SAMPLE-1], i_cur};
    assign bit_dec = sum[SIZE_SAMPLE];
    assign accept  = i_valid_input && o_ready;

    assign unused_bits = ^{i_data[79:SIZE_SAMPLE], sum[SIZE_SAMPLE-1:0]};

    assign next_shift = {shift_q[phase], bit_dec};

    always_comb begin
        err_cnt = 0;
        for (int k = 0; k < SIZE_PREAMBLE; k++)
            err_cnt += int'(next_shift[k] ^ PREAMBLE[k]);
    end

    assign hit = (err_cnt <= MAX_ERR);

    assign payload_bit = accept && (state_q == PAYLOAD) && (phase == lock_phase);
    assign byte_next   = {byte_q, bit_dec};
    assign byte_done   = payload_bit && (bit_cnt == LAST_BIT);
    assign pack_done   = byte_done && (byte_cnt == LAST_BYTE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT:    if (accept && hit) state_d = PAYLOAD;
            PAYLOAD: if (pack_done) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state_q <= HUNT;
        else          state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            i_prev     <= '0;
            phase      <= 1'b0;
            lock_phase <= 1'b0;
            shift_q[0] <= '0;
            shift_q[1] <= '0;
            byte_q     <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            wr_pend    <= 1'b0;
            wr_last    <= 1'b0;
            wr_data    <= '0;
        end else begin
            wr_pend <= byte_done;
            if (accept) begin
                i_prev <= i_cur;
                phase  <= ~phase;
            end
            if (accept && state_q == HUNT) begin
                shift_q[phase] <= next_shift[SIZE_PREAMBLE-2:0];
                if (hit) begin
                    lock_phase <= phase;
                    bit_cnt    <= '0;
                    byte_cnt   <= '0;
                end
            end
            if (payload_bit) begin
                byte_q  <= byte_next[SIZE_OUTPUT_BIT-2:0];
                bit_cnt <= bit_cnt + 1'b1;
            end
            // Completed byte is staged one cycle, then written to the FIFO
            if (byte_done) begin
                wr_data  <= byte_next;
                wr_last  <= (byte_cnt == LAST_BYTE);
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (pack_done) begin
                shift_q[0] <= '0;
                shift_q[1] <= '0;
            end
        end
    end

    assign rd_en = o_valid_output && i_ready;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                fifo_data[k] <= '0;
                fifo_last[k] <= 1'b0;
            end
        end else begin
            if (wr_pend) begin
                fifo_data[wr_ptr] <= wr_data;
                fifo_last[wr_ptr] <= wr_last;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_pend, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign o_ready        = (count != FULL_CNT);
    assign o_valid_output = (count != '0);
    assign o_data         = o_valid_output ? fifo_data[rd_ptr] : '0;
    assign o_last         = o_valid_output && fifo_last[rd_ptr];
    assign o_lock         = (state_q == PAYLOAD);

endmodule
